// File: rtl/rv_pkg.sv
// Shared fetch-path definitions: FSM encoding, NOP word, instruction field positions.
// FETCH_MISALIGN_TRAP_EN adds the HALT state used by the misaligned-redirect trap.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
        , ST_HALT = 3'd4
`endif
    } fstate_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC select: sequential PC+4 (wrapping) or word-aligned redirect target.
// FETCH_MISALIGN_TRAP_EN exposes the misaligned-redirect flag.
module pc_next
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            pcsrc,
    input  logic [XLEN-1:0] pctarget,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            misaligned,
`endif
    output logic [XLEN-1:0] next_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Low target bits are dropped so fetch addresses are always word aligned.
    always_comb begin
        next_pc = pcsrc ? (pctarget & ALIGN_MASK) : pc + XLEN'(4);
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = pcsrc && (pctarget[1:0] != 2'b00);
    end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: request, wait for data, present to the datapath, advance PC.
// FETCH_MISALIGN_TRAP_EN enables the sticky misalign flag and HALT state.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);

    fstate_t         state_q, state_d;
    logic [XLEN-1:0] pc_q, instr_q, next_pc;
    logic            consume;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
`endif

    pc_next u_pc_next (
        .pc        (pc_q),
        .pcsrc     (PCSrc),
        .pctarget  (PCTarget),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned(misaligned),
`endif
        .next_pc   (next_pc)
    );

    assign consume = (state_q == ST_ISSUE) && instr_ready;

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Same-cycle rvalid with ready never lands here: REQ does not look at it.
                if (imem_rvalid) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_d = misaligned ? ST_HALT : ST_REQ;
`else
                    state_d = ST_REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if ((state_q == ST_WAIT) && imem_rvalid) instr_q <= imem_rdata;
            if (consume) begin
                pc_q <= next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (misaligned) misalign <= 1'b1;
`endif
            end
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign op        = instr_q[OP_MSB:OP_LSB];
    assign funct3    = instr_q[F3_MSB:F3_LSB];
    assign funct7    = instr_q[F7_MSB:F7_LSB];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address (current PC).
REQ-006 imem_ready  input  1  memory accepts request this cycle.
REQ-007 imem_rvalid  input  1  imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr_valid  output  1  instruction presented to the decoder/datapath.
REQ-010 instr_ready  input  1  datapath consumes the instruction this cycle.
REQ-011 instr  output  32  registered instruction word.
REQ-012 op / funct3 / funct7  output  7/3/7  instr[6:0], instr[14:12], instr[31:25].
REQ-013 pc  output  32  address of the instruction in instr.
REQ-014 PCSrc  input  1  redirect select from the control unit (branch taken or jump).
REQ-015 PCTarget  input  32  redirect address from the datapath.
REQ-016 misalign  output  1  sticky misaligned-redirect flag (present only with FETCH_MISALIGN_TRAP_EN).

Function
REQ-017 FSM states IDLE, REQ, WAIT, ISSUE (plus HALT with FETCH_MISALIGN_TRAP_EN).
REQ-018 IDLE: one cycle after reset deasserts, then REQ.
REQ-019 REQ: imem_req=1, imem_addr=PC held stable; on imem_ready -> WAIT.
REQ-020 WAIT: imem_req=0; on imem_rvalid capture imem_rdata into instr -> ISSUE; imem_rvalid outside WAIT is ignored.
REQ-021 ISSUE: instr_valid=1, instr/pc/op/funct3/funct7 held stable until instr_ready.
REQ-022 On instr_valid & instr_ready: PC <= PCSrc ? PCTarget : PC+4, then REQ next cycle; PCSrc/PCTarget are sampled only in this cycle.
REQ-023 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Minimum latency: imem_ready and imem_rvalid on first opportunity gives instr_valid 2 cycles after REQ entry; throughput 1 instruction per 3 cycles with zero-wait memory and instr_ready tied high.
REQ-025 imem_rvalid in the same cycle as imem_ready is not accepted; data is expected no earlier than the cycle after acceptance.
REQ-026 instr_valid and imem_req are never both high.

Reset
REQ-027 Reset overrides all inputs in any state, including mid-REQ or mid-WAIT; any later response from memory is dropped.
REQ-028 Reset values: state=IDLE, PC=RESET_PC, instr=32'h0000_0013 (NOP), imem_req=0, instr_valid=0, misalign=0.

Configuration
REQ-029 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with PCTarget[1:0]!=0 sets misalign=1, enters HALT; HALT keeps imem_req=0 and instr_valid=0 until reset.
REQ-030 Macro undefined: misalign port and HALT state absent; PCTarget[1:0] forced to 2'b00 on redirect.

Structure
REQ-031 Shared package rv_pkg holds FSM state encoding, NOP constant, opcode field slice positions, and XLEN=32.
REQ-032 One sub-module, pc_next: combinational PC+4 / PCTarget select and alignment check; FSM and registers stay in fetch_unit.

Verification
REQ-033 Reset with RESET_PC=0x100, zero-wait memory, instr_ready=1 -> imem_addr sequence 0x100, 0x104, 0x108; instr_valid every 3rd cycle.
REQ-034 imem_ready held low 4 cycles in REQ -> imem_req and imem_addr=0x100 stable all 4 cycles; no instr_valid.
REQ-035 instr_ready low 3 cycles in ISSUE -> instr, pc, op stable; no new imem_req until consumed.
REQ-036 PCSrc=1, PCTarget=0x40 at consume -> next imem_addr=0x40; PCSrc=1 while instr_valid=0 -> ignored.
REQ-037 PC=0xFFFF_FFFC, PCSrc=0 -> next imem_addr=0x0; reset asserted during WAIT, then imem_rvalid -> instr stays NOP, next fetch at RESET_PC.
REQ-038 With macro: PCTarget=0x42 -> misalign=1, imem_req stays 0 until reset; without macro: next imem_addr=0x40.
